periph_bus_arbiter: RTL and testbench

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

---
 rtl/periph_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_periph_bus_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// Two-master, one-outstanding-transaction arbiter in front of a peripheral bus.
// Round-robin on ties, per-transaction response timeout reported as an error response.
module periph_bus_arbiter #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [31:0]   m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic [3:0]    m0_mask_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    output logic          m0_err_o,

    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [31:0]   m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    input  logic [3:0]    m1_mask_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          m1_err_o,

    output logic          s_req_o,
    output logic          s_we_o,
    output logic [31:0]   s_addr_o,
    output logic [DW-1:0] s_wdata_o,
    output logic [3:0]    s_mask_o,
    input  logic          s_gnt_i,
    input  logic          s_rvalid_i,
    input  logic [DW-1:0] s_rdata_i
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Handshake: the bus request fires when s_req_o && s_gnt_i in the same cycle;
    // the selected master sees its gnt in that cycle and must hold its fields until then.
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] count_q;
    logic          last_gnt_q;
    logic          owner_q;
    logic          sel;
    logic          fire;
    logic          timeout;

    // Tie goes to the master that did not win last time; otherwise the lone requester.
    assign sel     = (m0_req_i && m1_req_i) ? ~last_gnt_q : m1_req_i;
    assign fire    = s_req_o && s_gnt_i;
    assign timeout = (count_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fire) state_d = RESP;
            RESP: if (s_rvalid_i || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_mask_o  = '0;
        m0_gnt_o  = 1'b0;
        m1_gnt_o  = 1'b0;
        if (rst_n && state_q == IDLE && (m0_req_i || m1_req_i)) begin
            s_req_o   = 1'b1;
            s_we_o    = sel ? m1_we_i    : m0_we_i;
            s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
            s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
            s_mask_o  = sel ? m1_mask_i  : m0_mask_i;
            m0_gnt_o  = s_gnt_i && !sel;
            m1_gnt_o  = s_gnt_i && sel;
        end
    end

    // Response path: rvalid is a one-cycle pulse; rdata/err hold until the next pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q  <= 1'b1;
            owner_q     <= 1'b0;
            count_q     <= '0;
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m0_err_o    <= 1'b0;
            m1_err_o    <= 1'b0;
            m0_rdata_o  <= '0;
            m1_rdata_o  <= '0;
        end else begin
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            if (fire) begin
                owner_q    <= sel;
                last_gnt_q <= sel;
                count_q    <= '0;
            end else if (state_q == RESP) begin
                // A real response beats a timeout landing in the same cycle.
                if (s_rvalid_i || timeout) begin
                    if (owner_q) begin
                        m1_rvalid_o <= 1'b1;
                        m1_rdata_o  <= s_rvalid_i ? s_rdata_i : '0;
                        m1_err_o    <= !s_rvalid_i;
                    end else begin
                        m0_rvalid_o <= 1'b1;
                        m0_rdata_o  <= s_rvalid_i ? s_rdata_i : '0;
                        m0_err_o    <= !s_rvalid_i;
                    end
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: arbitration, stalls, responses, timeout and reset.
module tb_periph_bus_arbiter;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0]   m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic [3:0]    m0_mask_i, m1_mask_i;
    logic          m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
    logic [31:0]   s_addr_o;
    logic [DW-1:0] s_wdata_o, s_rdata_i;
    logic [3:0]    s_mask_o;

    int n_cmp = 0;
    int n_err = 0;

    periph_bus_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_mask_i(m0_mask_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_mask_i(m1_mask_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_mask_o(s_mask_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_req_i = 1'b1; m1_req_i = 1'b1; m0_we_i = 1'b0; m1_we_i = 1'b1;
        m0_addr_i = 32'h1000_0000; m1_addr_i = 32'h2000_0004;
        m0_wdata_i = 32'h0000_00AA; m1_wdata_i = 32'h0000_00BB;
        m0_mask_i = 4'hF; m1_mask_i = 4'h1;
        s_gnt_i = 1'b1; s_rvalid_i = 1'b0; s_rdata_i = '0;
        step();
        step();
        n_cmp++; if ({m0_gnt_o, m1_gnt_o} !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt_o, m1_gnt_o}); end
        n_cmp++; if (s_req_o !== 1'b0) begin n_err++; $display("FAIL reset_s_req: got %b want 0", s_req_o); end
        n_cmp++; if ({m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o} !== 4'b0000) begin n_err++; $display("FAIL reset_rvalid_err: got %b want 0000", {m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o}); end
        n_cmp++; if ((m0_rdata_o | m1_rdata_o) !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h/%h want 0", m0_rdata_o, m1_rdata_o); end
        m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_tie_from_reset();
        m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1;
        #1;
        n_cmp++; if ({m1_gnt_o, m0_gnt_o} !== 2'b01) begin n_err++; $display("FAIL tie_first_gnt: got %b want 01", {m1_gnt_o, m0_gnt_o}); end
        n_cmp++; if (s_addr_o !== 32'h1000_0000 || s_req_o !== 1'b1) begin n_err++; $display("FAIL tie_mirror_m0: got req=%b addr=%h want 1 10000000", s_req_o, s_addr_o); end
        step();
        m0_req_i = 1'b0;
        #1;
        n_cmp++; if (s_req_o !== 1'b0 || m1_gnt_o !== 1'b0) begin n_err++; $display("FAIL resp_no_req: got s_req=%b m1_gnt=%b want 0 0", s_req_o, m1_gnt_o); end
        s_rvalid_i = 1'b1; s_rdata_i = 32'h1234_5678;
        step();
        s_rvalid_i = 1'b0;
        #1;
        n_cmp++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h1234_5678 || m0_err_o !== 1'b0) begin n_err++; $display("FAIL tie_m0_resp: got v=%b d=%h e=%b want 1 12345678 0", m0_rvalid_o, m0_rdata_o, m0_err_o); end
        n_cmp++; if (m1_rvalid_o !== 1'b0) begin n_err++; $display("FAIL tie_m1_no_rvalid: got %b want 0", m1_rvalid_o); end
        n_cmp++; if (m1_gnt_o !== 1'b1 || s_addr_o !== 32'h2000_0004 || s_we_o !== 1'b1) begin n_err++; $display("FAIL tie_m1_gnt_in_pulse: got g=%b a=%h we=%b want 1 20000004 1", m1_gnt_o, s_addr_o, s_we_o); end
        step();
        m1_req_i = 1'b0; s_gnt_i = 1'b0;
        #1;
        n_cmp++; if (m0_rvalid_o !== 1'b0 || m0_rdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL m0_rdata_hold: got v=%b d=%h want 0 12345678", m0_rvalid_o, m0_rdata_o); end
        s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFE_F00D;
        step();
        s_rvalid_i = 1'b0;
        #1;
        n_cmp++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'hCAFE_F00D || m1_err_o !== 1'b0) begin n_err++; $display("FAIL m1_resp: got v=%b d=%h e=%b want 1 cafef00d 0", m1_rvalid_o, m1_rdata_o, m1_err_o); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq;
        exp_seq = 3'b010;
        m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({m1_gnt_o, m0_gnt_o} !== (exp_seq[i] ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_gnt_%0d: got %b want m%0d", i, {m1_gnt_o, m0_gnt_o}, exp_seq[i]); end
            step();
            if (exp_seq[i]) m1_req_i = 1'b0;
            s_rvalid_i = 1'b1; s_rdata_i = 32'h0000_0100 + i;
            step();
            s_rvalid_i = 1'b0;
            if (i == 2) begin m0_req_i = 1'b0; s_gnt_i = 1'b0; end
            #1;
            n_cmp++; if ((exp_seq[i] ? m1_rvalid_o : m0_rvalid_o) !== 1'b1) begin n_err++; $display("FAIL rr_rvalid_%0d: got 0 want 1 on m%0d", i, exp_seq[i]); end
        end
        step();
    endtask

    task automatic test_timeout();
        m1_req_i = 1'b1; s_gnt_i = 1'b1;
        #1;
        n_cmp++; if (m1_gnt_o !== 1'b1) begin n_err++; $display("FAIL to_gnt: got %b want 1", m1_gnt_o); end
        step();
        m1_req_i = 1'b0; s_gnt_i = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            n_cmp++; if (m1_rvalid_o !== 1'b0) begin n_err++; $display("FAIL to_early_rvalid_%0d: got 1 want 0", i); end
            step();
        end
        n_cmp++; if (m1_rvalid_o !== 1'b1 || m1_err_o !== 1'b1 || m1_rdata_o !== 32'h0) begin n_err++; $display("FAIL to_resp: got v=%b e=%b d=%h want 1 1 0", m1_rvalid_o, m1_err_o, m1_rdata_o); end
        step();
        n_cmp++; if (m1_rvalid_o !== 1'b0) begin n_err++; $display("FAIL to_pulse_width: got %b want 0", m1_rvalid_o); end
    endtask

    task automatic test_gnt_stall();
        m0_we_i = 1'b1; m0_addr_i = 32'h4000_0010; m0_wdata_i = 32'hDEAD_BEEF; m0_mask_i = 4'b0011;
        m0_req_i = 1'b1; s_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (m0_gnt_o !== 1'b0 || s_req_o !== 1'b1) begin n_err++; $display("FAIL stall_nogrant_%0d: got g=%b r=%b want 0 1", i, m0_gnt_o, s_req_o); end
            n_cmp++; if ({s_we_o, s_addr_o, s_wdata_o, s_mask_o} !== {1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'b0011}) begin n_err++; $display("FAIL stall_mirror_%0d: got %b %h %h %b want 1 40000010 deadbeef 0011", i, s_we_o, s_addr_o, s_wdata_o, s_mask_o); end
            step();
        end
        s_gnt_i = 1'b1;
        #1;
        n_cmp++; if (m0_gnt_o !== 1'b1) begin n_err++; $display("FAIL stall_grant: got %b want 1", m0_gnt_o); end
        step();
        m0_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h0000_0001;
        step();
        s_rvalid_i = 1'b0;
        #1;
        n_cmp++; if (m0_rvalid_o !== 1'b1 || m0_err_o !== 1'b0 || m0_rdata_o !== 32'h0000_0001) begin n_err++; $display("FAIL store_ack: got v=%b e=%b d=%h want 1 0 00000001", m0_rvalid_o, m0_err_o, m0_rdata_o); end
        m0_we_i = 1'b0;
    endtask

    task automatic test_reset_in_resp();
        m0_req_i = 1'b1; s_gnt_i = 1'b1;
        step();
        rst_n = 1'b0; m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1;
        #1;
        n_cmp++; if ({m0_gnt_o, m1_gnt_o, s_req_o} !== 3'b000) begin n_err++; $display("FAIL rst_gnt_sreq: got %b want 000", {m0_gnt_o, m1_gnt_o, s_req_o}); end
        step();
        rst_n = 1'b1; m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h5555_AAAA;
        #1;
        n_cmp++; if (m0_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rdata_clear: got %h want 0", m0_rdata_o); end
        step();
        s_rvalid_i = 1'b0;
        #1;
        n_cmp++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL rst_late_rvalid: got %b want 00", {m0_rvalid_o, m1_rvalid_o}); end
        step();
        n_cmp++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL rst_no_pulse: got %b want 00", {m0_rvalid_o, m1_rvalid_o}); end
        m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1;
        #1;
        n_cmp++; if ({m1_gnt_o, m0_gnt_o} !== 2'b01) begin n_err++; $display("FAIL rst_tie_m0: got %b want 01", {m1_gnt_o, m0_gnt_o}); end
        step();
        m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h0BAD_0001;
        step();
        s_rvalid_i = 1'b0;
        #1;
        n_cmp++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h0BAD_0001) begin n_err++; $display("FAIL rst_after_txn: got v=%b d=%h want 1 0bad0001", m0_rvalid_o, m0_rdata_o); end
    endtask

    task automatic test_coincide();
        m0_req_i = 1'b1; s_gnt_i = 1'b1;
        step();
        m0_req_i = 1'b0; s_gnt_i = 1'b0;
        repeat (TIMEOUT - 1) step();
        n_cmp++; if (m0_rvalid_o !== 1'b0) begin n_err++; $display("FAIL co_early: got %b want 0", m0_rvalid_o); end
        s_rvalid_i = 1'b1; s_rdata_i = 32'hA5A5_0001;
        step();
        s_rvalid_i = 1'b0;
        #1;
        n_cmp++; if (m0_rvalid_o !== 1'b1 || m0_err_o !== 1'b0 || m0_rdata_o !== 32'hA5A5_0001) begin n_err++; $display("FAIL co_resp_wins: got v=%b e=%b d=%h want 1 0 a5a50001", m0_rvalid_o, m0_err_o, m0_rdata_o); end
        step();
    endtask

    initial begin
        test_reset();
        test_tie_from_reset();
        test_round_robin();
        test_timeout();
        test_gnt_stall();
        test_reset_in_resp();
        test_coincide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
